// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: width/reset defaults and
// the next-PC selection encoding.
package pc_pkg;

    localparam int unsigned PC_WIDTH_DEFAULT = 16;
    localparam logic [PC_WIDTH_DEFAULT-1:0] RESET_VECTOR_DEFAULT = 16'h0000;

    // Source of the value loaded into PC on the next rising edge
    typedef enum logic [1:0] {
        PC_HOLD   = 2'd0,
        PC_BRANCH = 2'd1,
        PC_INCR   = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/pc_if.sv
// Control/status bundle between the control unit (master) and pc_unit (slave).
interface pc_if #(
    parameter int unsigned PC_WIDTH = 16
);

    logic                halt;
    logic                branch;
    logic                zero;
    logic [PC_WIDTH-1:0] absolute_addr;
    logic [PC_WIDTH-1:0] pc;
    logic                halted;

    modport master (
        output halt, branch, zero, absolute_addr,
        input  pc, halted
    );

    modport slave (
        input  halt, branch, zero, absolute_addr,
        output pc, halted
    );

endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: hold beats a taken branch, which beats the
// increment. The increment wraps modulo 2^PC_WIDTH with no carry-out.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int unsigned PC_WIDTH = PC_WIDTH_DEFAULT
) (
    input  logic                hold_req,
    input  logic                branch,
    input  logic                zero,
    input  logic [PC_WIDTH-1:0] pc,
    input  logic [PC_WIDTH-1:0] target,
    output pc_sel_e             sel,
    output logic [PC_WIDTH-1:0] pc_next
);

    // Priority decode of the next-PC source
    always_comb begin
        sel = PC_INCR;
        if (hold_req) begin
            sel = PC_HOLD;
        end else if (branch && zero) begin
            sel = PC_BRANCH;
        end
    end

    // Next-PC mux driven by the decoded source
    always_comb begin
        pc_next = pc + PC_WIDTH'(1);
        unique case (sel)
            PC_HOLD:   pc_next = pc;
            PC_BRANCH: pc_next = target;
            PC_INCR:   pc_next = pc + PC_WIDTH'(1);
            default:   pc_next = pc + PC_WIDTH'(1);
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter register plus Halted status flag.
// Optional feature macro: PC_STICKY_HALT_EN -- once HALT is seen, Halted stays
// set and PC stays frozen until reset.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned                PC_WIDTH     = PC_WIDTH_DEFAULT,
    parameter logic [PC_WIDTH_DEFAULT-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    pc_if.slave  bus
);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;
    logic                halted_q;
    logic                halted_d;
    logic                hold_req;
    pc_sel_e             sel;

    // Freeze request and next Halted value, per-cycle or sticky
    always_comb begin
`ifdef PC_STICKY_HALT_EN
        hold_req = bus.halt | halted_q;
        halted_d = bus.halt | halted_q;
`else
        hold_req = bus.halt;
        halted_d = bus.halt;
`endif
    end

    pc_next_sel #(
        .PC_WIDTH (PC_WIDTH)
    ) u_next_sel (
        .hold_req (hold_req),
        .branch   (bus.branch),
        .zero     (bus.zero),
        .pc       (pc_q),
        .target   (bus.absolute_addr),
        .sel      (sel),
        .pc_next  (pc_d)
    );

    // PC and Halted state; reset aborts any halt or branch in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= PC_WIDTH'(RESET_VECTOR);
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    assign bus.pc     = pc_q;
    assign bus.halted = halted_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit; covers both builds of
// PC_STICKY_HALT_EN.
module tb_pc_unit;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    pc_if #(.PC_WIDTH(16)) bus ();

    pc_unit #(
        .PC_WIDTH     (16),
        .RESET_VECTOR (16'h0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic h, input logic b, input logic z, input logic [15:0] a);
        bus.halt          = h;
        bus.branch        = b;
        bus.zero          = z;
        bus.absolute_addr = a;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        #1 rst_n = 1'b0;
        #1;
        check("reset_pc_async", bus.pc, 16'h0000);
        check("reset_halted_async", {15'd0, bus.halted}, 16'h0000);

        // Branch and halt requested while in reset must be ignored
        drive(1'b1, 1'b1, 1'b1, 16'h0055);
        tick();
        check("reset_abort_pc", bus.pc, 16'h0000);
        check("reset_abort_halted", {15'd0, bus.halted}, 16'h0000);

        #2;
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        rst_n = 1'b1;
        #1;
        check("release_pc", bus.pc, 16'h0000);
        tick();
        check("incr_1", bus.pc, 16'h0001);
        bus.zero = 1'b1;   // Zero alone must not redirect
        tick();
        check("incr_2_zero_ignored", bus.pc, 16'h0002);
        bus.zero = 1'b0;
        tick();
        check("incr_3", bus.pc, 16'h0003);

        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        check("halt_1_pc", bus.pc, 16'h0003);
        check("halt_1_halted", {15'd0, bus.halted}, 16'h0001);
        tick();
        check("halt_2_pc", bus.pc, 16'h0003);
        check("halt_2_halted", {15'd0, bus.halted}, 16'h0001);

`ifdef PC_STICKY_HALT_EN
        // Sticky halt: PC frozen after HALT falls, until reset
        drive(1'b0, 1'b1, 1'b1, 16'h0F0F);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sticky_pc", bus.pc, 16'h0003);
            check("sticky_halted", {15'd0, bus.halted}, 16'h0001);
        end
        #2 rst_n = 1'b0;
        #1;
        check("sticky_reset_pc", bus.pc, 16'h0000);
        check("sticky_reset_halted", {15'd0, bus.halted}, 16'h0000);
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        #2 rst_n = 1'b1;
        tick();
        check("sticky_after_reset", bus.pc, 16'h0001);
        check("sticky_after_reset_halted", {15'd0, bus.halted}, 16'h0000);
`else
        drive(1'b0, 1'b1, 1'b0, 16'h0000);
        tick();
        check("branch_not_taken", bus.pc, 16'h0004);
        check("unhalt_halted", {15'd0, bus.halted}, 16'h0000);

        drive(1'b0, 1'b1, 1'b1, 16'h000F);
        tick();
        check("branch_taken", bus.pc, 16'h000F);
        drive(1'b0, 1'b0, 1'b1, 16'h000F);
        tick();
        check("incr_after_branch", bus.pc, 16'h0010);

        drive(1'b1, 1'b1, 1'b1, 16'h0100);
        tick();
        check("halt_beats_branch", bus.pc, 16'h0010);
        check("halt_beats_branch_halted", {15'd0, bus.halted}, 16'h0001);

        drive(1'b0, 1'b1, 1'b1, 16'hFFFF);
        tick();
        check("branch_all_ones", bus.pc, 16'hFFFF);
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        check("wrap_to_zero", bus.pc, 16'h0000);
        tick();
        check("incr_after_wrap", bus.pc, 16'h0001);

        bus.halt = 1'b1;
        tick();
        check("halt_before_reset", {15'd0, bus.halted}, 16'h0001);
        #2 rst_n = 1'b0;
        #1;
        check("midcycle_reset_pc", bus.pc, 16'h0000);
        check("midcycle_reset_halted", {15'd0, bus.halted}, 16'h0000);
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        #2 rst_n = 1'b1;
        tick();
        check("after_reset_incr", bus.pc, 16'h0001);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter PC_WIDTH, default 16, width of the program counter and of the branch target.
REQ-002 Parameter RESET_VECTOR, default 16'h0000, value loaded into PC on reset.
REQ-003 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 HALT  input  1  freeze request; when high, PC holds its value.
REQ-006 Branch  input  1  conditional-branch signal from the control unit.
REQ-007 Zero  input  1  zero flag from the ALU; qualifies Branch.
REQ-008 AbsoluteAddr  input  PC_WIDTH  absolute branch target for be/bne.
REQ-009 PC  output  PC_WIDTH  current program count, registered.
REQ-010 Halted  output  1  registered status; high in any cycle after an edge where HALT was sampled high (see REQ-022).

Function
REQ-011 On each rising CLK edge with RESET high, PC SHALL load exactly one next value, chosen by priority: HALT, then taken branch, then increment.
REQ-012 HALT=1: PC SHALL hold, regardless of Branch or Zero.
REQ-013 HALT=0, Branch=1, Zero=1: PC SHALL load AbsoluteAddr in the next cycle (1-cycle latency, no delay slot).
REQ-014 HALT=0, Branch=1, Zero=0: branch not taken; PC SHALL increment by 1.
REQ-015 HALT=0, Branch=0: PC SHALL increment by 1; Zero is ignored.
REQ-016 Increment SHALL be modulo 2^PC_WIDTH; at all-ones, PC SHALL wrap to 0 without any flag.
REQ-017 A taken branch to all-ones SHALL be legal; the following increment wraps per REQ-016.
REQ-018 Halted SHALL register HALT each edge (Halted = HALT sampled at the previous edge) unless overridden by REQ-022.
REQ-019 The next-PC selection SHALL be purely combinational from the inputs and current PC; PC and Halted are the only state.

Reset
REQ-020 While RESET=0, PC SHALL equal RESET_VECTOR and Halted SHALL equal 0, asynchronously and independent of CLK.
REQ-021 On the first rising edge after RESET deasserts with HALT=0 and Branch=0, PC SHALL become RESET_VECTOR+1; reset asserted mid-halt or mid-branch SHALL abort that operation.

Configuration
REQ-022 Macro PC_STICKY_HALT_EN: when defined, Halted SHALL latch to 1 on the first edge with HALT=1 and PC SHALL hold from then on even if HALT falls, until RESET is asserted; when undefined, HALT acts per cycle (REQ-012, REQ-018).

Structure
REQ-023 Shared package pc_pkg SHALL hold the PC_WIDTH default, the RESET_VECTOR default, and an enum of next-PC selections (PC_HOLD, PC_BRANCH, PC_INCR).
REQ-024 A combinational sub-module pc_next_sel SHALL compute the selection enum and the next-PC value; pc_unit holds only the registers.

Verification
REQ-025 Pulse RESET low, release, drive HALT=0 and Branch=0 for 3 edges -> PC = 0, 1, 2, 3.
REQ-026 From PC=3, drive HALT=1 for 2 edges -> PC stays 3 and Halted=1; then HALT=0 and Branch=1, Zero=0 -> PC=4.
REQ-027 PC=4, drive Branch=1, Zero=1, AbsoluteAddr=16'h000F -> PC=16'h000F next edge; then Branch=0 -> 16'h0010.
REQ-028 Drive HALT=1, Branch=1, Zero=1, AbsoluteAddr=16'h0100 -> PC unchanged (HALT wins).
REQ-029 Branch to 16'hFFFF, then increment -> PC = 16'h0000; then assert RESET mid-cycle -> PC = 0 immediately, before the next edge.
REQ-030 With PC_STICKY_HALT_EN defined: HALT high for 1 edge, then low for 3 edges -> PC frozen and Halted=1 until RESET is asserted.
